cam_capture_rgb444: RTL and testbench
=====================================

# cam_capture_rgb444

Capture stage between the OV7670 camera pins and the dual-port frame buffer. It runs on the camera pixel clock and tracks `CAM_vsync`/`CAM_href`. It assembles each pair of RGB444 bytes into one 12-bit pixel and issues single-cycle writes to port A of the 160x120 buffer. The VGA side reads port B through `DP_RAM_addr_out` and is outside this block.

## Interface
- `IMG_W`, 160, pixels per line stored
- `IMG_H`, 120, lines per frame stored
- `AW`, 15, buffer address width
- `DW`, 12, pixel width {R,G,B} 4 bits each
- `pclk`  in  1  camera pixel clock; the only clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `CAM_vsync`  in  1  frame sync, high during vertical blank
- `CAM_href`  in  1  line valid, high while bytes are valid
- `CAM_px_data`  in  8  camera byte
- `DP_RAM_addr_in`  out  AW  write address
- `DP_RAM_data_in`  out  DW  write data
- `DP_RAM_regW`  out  1  write strobe, one cycle per pixel
- `frame_done`  out  1  one-cycle pulse at end of a captured frame
- `overflow`  out  1  sticky: a pixel fell outside IMG_W x IMG_H

## Operation
- Inputs are registered once (`vs_q`, `hr_q`). Edges are detected against a second register stage.
- FSM states:
  - WAIT_FRAME (reset state): leave on falling edge of `vs_q`; clear `row`, `col`, `overflow` → IDLE_LINE.
  - IDLE_LINE: `hr_q`=1 → BYTE1 action on the same edge: latch R = byte[3:0].
  - BYTE1: `hr_q`=1 → BYTE2: assemble {R, byte[7:4] G, byte[3:0] B} and request a write; `hr_q`=0 → discard R → IDLE_LINE, ending the line.
  - BYTE2: `hr_q`=1 → BYTE1, latch R; `hr_q`=0 → IDLE_LINE, ending the line.
  - Any state: rising edge of `vs_q` → WAIT_FRAME. If `row`>0, pulse `frame_done`.
- Line end (falling edge of `hr_q`):
  - `row` increments, saturating at IMG_H.
  - `col` clears.
  - An odd trailing byte is dropped with no write.
- Address is `row*IMG_W + col`. For IMG_W=160 this is computed as (row<<7)+(row<<5)+col, with no multiplier. Width is AW bits and cannot wrap for in-range pixels.
- Writes are requested only while `col`<IMG_W and `row`<IMG_H. An out-of-range pixel:
  - produces no write;
  - sets `overflow`;
  - still advances `col`, saturating at IMG_W.
- `col` increments after each assembled pixel.

## Timing
- Reset values:
  - `DP_RAM_addr_in`=0, `DP_RAM_data_in`=0, `DP_RAM_regW`=0
  - `frame_done`=0, `overflow`=0
  - FSM=WAIT_FRAME, `row`=`col`=0
- Input latency: one register stage. A byte present at edge N is acted on at edge N+1.
- Write timing:
  - `DP_RAM_regW`, `DP_RAM_addr_in` and `DP_RAM_data_in` are registered together.
  - They are high/valid for exactly the one cycle after the edge that consumed the second byte.
  - Address and data hold until the next write; `regW` drops.
- Write rate: at most one write per 2 pclk cycles. Back-to-back pixels never merge strobes.
- `frame_done` is asserted in the cycle following detection of the `vs_q` rising edge, for one cycle.
- Simultaneous events:
  - `vs_q` rising in the same cycle as a pending second byte: the write still issues, then the FSM enters WAIT_FRAME.
  - `href` falling in the same cycle as `vsync` rising: line end is applied first, then frame end.
- Mid-frame `rst`: all state clears immediately (async). Capture restarts only after the next `vsync` falling edge. No partial write is emitted.
- Power-up inside a frame (`vsync` already low): no writes until a full `vsync` high→low sequence is seen.

## Configuration
- `CAM_TEST_PATTERN_EN`:
  - Defined: the camera byte content is ignored. `DP_RAM_data_in` = {col[7:4], row[6:3], col[3:0]}. Timing, addressing, strobes and flags are unchanged and still driven by `vsync`/`href`.
  - Undefined: data comes from the camera bytes as described above.

## Test plan
- Reset: `rst`=1 with arbitrary pins → all outputs 0, FSM in WAIT_FRAME. Release while `vsync`=1 → no `regW` until `vsync` falls.
- Standard frame of 120 lines x 320 bytes, 4 blank lines, bytes 0x0F on even lines and 0xF0 on odd lines:
  - exactly 19200 `regW` pulses;
  - line 0 col 0 writes addr 0 data 12'hF0F;
  - line 1 col 0 writes addr 160 data 12'h0F0;
  - last write at addr 19199;
  - one `frame_done` pulse; `overflow`=0.
- Short line of 101 bytes: 50 writes at addr row*160+0..49, odd byte dropped. Next line starts at (row+1)*160.
- Long line of 330 bytes on row 119, plus a 121st line: no writes beyond col 159 or row 119; `overflow`=1 and stays set until the next `vsync` fall.
- `rst` pulsed mid-line at row 60: `regW` is 0 from the reset edge. Capture resumes at addr 0 only after the next `vsync` high→low.
- With `CAM_TEST_PATTERN_EN` defined: row 8 col 17 writes data 12'h111 at addr 1297, regardless of pin data.

Source files
------------

// File: rtl/cam_capture_rgb444.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and writes them to port A of a 160x120 frame buffer.
// Optional build macro CAM_TEST_PATTERN_EN replaces pixel data with a {col,row,col} coordinate pattern.
module cam_capture_rgb444 #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          overflow
);

  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    IDLE_LINE,
    BYTE1,
    BYTE2
  } state_t;

  state_t        state, state_d;
  logic          vs_q, hr_q, vs_qq, hr_qq;
  logic [RW-1:0] row, row_d;
  logic [CW-1:0] col, col_d;
  logic          ovf_d, wr_d, fd_d;
  logic          vs_rise, vs_fall, hr_fall;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      hr_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_qq <= 1'b0;
    end else begin
      vs_q  <= CAM_vsync;
      hr_q  <= CAM_href;
      vs_qq <= vs_q;
      hr_qq <= hr_q;
    end
  end

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_fall = ~hr_q & hr_qq;

  generate
    if (IMG_W == 160) begin : g_shift_addr
      assign pix_addr = (AW'(row) << 7) + (AW'(row) << 5) + AW'(col);
    end else begin : g_mul_addr
      assign pix_addr = AW'(int'(row) * IMG_W + int'(col));
    end
  endgenerate

`ifdef CAM_TEST_PATTERN_EN
  logic [7:0] col8;
  logic [6:0] row7;
  assign col8     = 8'(col);
  assign row7     = 7'(row);
  assign pix_data = DW'({col8[7:4], row7[6:3], col8[3:0]});
`else
  logic [7:0] px_q;
  logic [3:0] r_lat;
  logic       latch_r;

  // R nibble is taken from the first byte of each pair
  assign latch_r  = hr_q && ((state == IDLE_LINE) || (state == BYTE2));
  assign pix_data = DW'({r_lat, px_q});

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      px_q  <= 8'h00;
      r_lat <= 4'h0;
    end else begin
      px_q <= CAM_px_data;
      if (latch_r) r_lat <= px_q[3:0];
    end
  end
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state          <= WAIT_FRAME;
      row            <= '0;
      col            <= '0;
      overflow       <= 1'b0;
      frame_done     <= 1'b0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
    end else begin
      state       <= state_d;
      row         <= row_d;
      col         <= col_d;
      overflow    <= ovf_d;
      frame_done  <= fd_d;
      DP_RAM_regW <= wr_d;
      if (wr_d) begin
        DP_RAM_addr_in <= pix_addr;
        DP_RAM_data_in <= pix_data;
      end
    end
  end

  always_comb begin
    state_d = state;
    row_d   = row;
    col_d   = col;
    ovf_d   = overflow;
    wr_d    = 1'b0;
    fd_d    = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vs_fall) begin
          state_d = IDLE_LINE;
          row_d   = '0;
          col_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      IDLE_LINE: begin
        if (hr_q) state_d = BYTE1;
      end
      BYTE1: begin
        if (hr_q) begin
          state_d = BYTE2;
          if ((col < CW'(IMG_W)) && (row < RW'(IMG_H))) wr_d = 1'b1;
          else ovf_d = 1'b1;
          if (col < CW'(IMG_W)) col_d = col + CW'(1);
        end else begin
          state_d = IDLE_LINE;
        end
      end
      BYTE2: begin
        state_d = hr_q ? BYTE1 : IDLE_LINE;
      end
      default: state_d = WAIT_FRAME;
    endcase

    // line end lands before frame end so a closing line counts toward frame_done
    if ((state != WAIT_FRAME) && hr_fall) begin
      col_d = '0;
      if (row < RW'(IMG_H)) row_d = row + RW'(1);
    end
    if (vs_rise) begin
      state_d = WAIT_FRAME;
      fd_d    = (row_d != '0);
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Randomized bench for cam_capture_rgb444 with a line/pixel-level reference model.
module tb_cam_capture_rgb444;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int AW    = 15;
  localparam int DW    = 12;

  logic          pclk = 1'b0;
  logic          rst;
  logic          CAM_vsync;
  logic          CAM_href;
  logic [7:0]    CAM_px_data;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_regW;
  logic          frame_done;
  logic          overflow;

  cam_capture_rgb444 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .rst(rst), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .DP_RAM_addr_in(DP_RAM_addr_in),
    .DP_RAM_data_in(DP_RAM_data_in), .DP_RAM_regW(DP_RAM_regW),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] obs_q[$];
  logic [AW+DW-1:0] exp_q[$];
  int   fd_cnt    = 0;
  int   merge_cnt = 0;
  logic prev_w    = 1'b0;
  int   m_row;
  logic m_ovf;

  always @(posedge pclk) begin
    #1;
    if (DP_RAM_regW) begin
      obs_q.push_back({DP_RAM_addr_in, DP_RAM_data_in});
      if (prev_w) merge_cnt++;
    end
    prev_w = DP_RAM_regW;
    if (frame_done) fd_cnt++;
  end

  function automatic logic [DW-1:0] model_px(input int row, input int col,
                                             input logic [7:0] b0, input logic [7:0] b1);
`ifdef CAM_TEST_PATTERN_EN
    logic [7:0] c;
    logic [6:0] r;
    c = col[7:0];
    r = row[6:0];
    return {c[7:4], r[6:3], c[3:0]};
`else
    return {b0[3:0], b1[7:4], b1[3:0]};
`endif
  endfunction

  task automatic tick();
    @(negedge pclk);
  endtask

  // end_mode 0: normal; 1: href falls with vsync rising; 2: vsync rises with the last byte
  task automatic send_line(input int nbytes, input int pat, input int end_mode);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int i = 0; i < nbytes; i++) begin
      v = (pat < 0) ? 8'($urandom_range(0, 255)) : 8'(pat);
      b.push_back(v);
      CAM_href    = 1'b1;
      CAM_px_data = v;
      if (end_mode == 2 && i == nbytes - 1) CAM_vsync = 1'b1;
      tick();
    end
    CAM_href    = 1'b0;
    CAM_px_data = 8'($urandom_range(0, 255));
    if (end_mode == 1) CAM_vsync = 1'b1;
    tick();
    for (int k = 0; k < nbytes / 2; k++) begin
      if (m_row < IMG_H && k < IMG_W)
        exp_q.push_back({AW'(m_row * IMG_W + k), model_px(m_row, k, b[2*k], b[2*k+1])});
      else
        m_ovf = 1'b1;
    end
    if (end_mode != 2) m_row++;
    repeat (3) tick();
  endtask

  task automatic begin_frame();
    obs_q.delete();
    exp_q.delete();
    fd_cnt    = 0;
    merge_cnt = 0;
    m_row     = 0;
    m_ovf     = 1'b0;
    CAM_href  = 1'b0;
    CAM_vsync = 1'b1;
    repeat (3) tick();
    CAM_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    CAM_href  = 1'b0;
    CAM_vsync = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    CAM_vsync   = 1'($urandom_range(0, 1));
    CAM_href    = 1'($urandom_range(0, 1));
    CAM_px_data = 8'($urandom_range(0, 255));
    repeat (3) tick();
    total++; if (DP_RAM_regW !== 1'b0) begin bad++; $display("FAIL rst_regW: got %b want 0", DP_RAM_regW); end
    total++; if (DP_RAM_addr_in !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", DP_RAM_addr_in); end
    total++; if (DP_RAM_data_in !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", DP_RAM_data_in); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    // release during vertical blank: href activity must not write
    obs_q.delete();
    CAM_vsync = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      CAM_href    = 1'($urandom_range(0, 1));
      CAM_px_data = 8'($urandom_range(0, 255));
      tick();
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_vs_high_writes: got %0d want 0", obs_q.size()); end
    // power-up inside a frame
    rst       = 1'b1;
    CAM_vsync = 1'b0;
    CAM_href  = 1'b0;
    tick();
    rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 40; i++) begin
      CAM_href    = 1'b1;
      CAM_px_data = 8'($urandom_range(0, 255));
      tick();
    end
    CAM_href = 1'b0;
    repeat (5) tick();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_in_frame_writes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_standard_frame();
    logic [AW+DW-1:0] got;
    begin_frame();
    for (int l = 0; l < IMG_H; l++) send_line(320, (l % 2 == 0) ? 8'h0F : 8'hF0, 0);
    end_frame();
    total++; if (obs_q.size() != 19200) begin bad++; $display("FAIL std_count: got %0d want 19200", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad < 20) $display("FAIL std_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    got = (obs_q.size() > 0) ? obs_q[0] : 'x;
`ifdef CAM_TEST_PATTERN_EN
    total++; if (got !== {15'd0, 12'h000}) begin bad++; $display("FAIL std_first: got %h want %h", got, {15'd0, 12'h000}); end
`else
    total++; if (got !== {15'd0, 12'hF0F}) begin bad++; $display("FAIL std_first: got %h want %h", got, {15'd0, 12'hF0F}); end
`endif
    got = (obs_q.size() > 160) ? obs_q[160] : 'x;
`ifdef CAM_TEST_PATTERN_EN
    total++; if (got !== {15'd160, 12'h000}) begin bad++; $display("FAIL std_line1: got %h want %h", got, {15'd160, 12'h000}); end
`else
    total++; if (got !== {15'd160, 12'h0F0}) begin bad++; $display("FAIL std_line1: got %h want %h", got, {15'd160, 12'h0F0}); end
`endif
    got = (obs_q.size() > 1297) ? obs_q[1297] : 'x;
`ifdef CAM_TEST_PATTERN_EN
    total++; if (got !== {15'd1297, 12'h111}) begin bad++; $display("FAIL std_r8c17: got %h want %h", got, {15'd1297, 12'h111}); end
`else
    total++; if (got !== {15'd1297, 12'hF0F}) begin bad++; $display("FAIL std_r8c17: got %h want %h", got, {15'd1297, 12'hF0F}); end
`endif
    got = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 'x;
    total++; if (got[AW+DW-1:DW] !== 15'd19199) begin bad++; $display("FAIL std_last_addr: got %0d want 19199", got[AW+DW-1:DW]); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL std_frame_done: got %0d want 1", fd_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL std_overflow: got %b want 0", overflow); end
    total++; if (merge_cnt != 0) begin bad++; $display("FAIL std_merged_strobes: got %0d want 0", merge_cnt); end
  endtask

  task automatic test_short_line();
    logic [AW+DW-1:0] got;
    begin_frame();
    send_line(320, -1, 0);
    send_line(101, -1, 0);
    send_line(320, -1, 0);
    end_frame();
    total++; if (obs_q.size() != 370) begin bad++; $display("FAIL short_count: got %0d want 370", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad < 20) $display("FAIL short_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    got = (obs_q.size() > 209) ? obs_q[209] : 'x;
    total++; if (got[AW+DW-1:DW] !== 15'd209) begin bad++; $display("FAIL short_last_col: got %0d want 209", got[AW+DW-1:DW]); end
    got = (obs_q.size() > 210) ? obs_q[210] : 'x;
    total++; if (got[AW+DW-1:DW] !== 15'd320) begin bad++; $display("FAIL short_next_row: got %0d want 320", got[AW+DW-1:DW]); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL short_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int maxa;
    begin_frame();
    for (int r = 0; r < IMG_H - 1; r++) send_line(4, -1, 0);
    send_line(330, -1, 0);
    send_line(20, -1, 0);
    end_frame();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    maxa = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (int'(obs_q[i][AW+DW-1:DW]) > maxa) maxa = int'(obs_q[i][AW+DW-1:DW]);
      if (i < exp_q.size()) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          if (bad < 20) $display("FAIL ovf_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    total++; if (maxa > 19199) begin bad++; $display("FAIL ovf_max_addr: got %0d want <=19199", maxa); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL ovf_frame_done: got %0d want 1", fd_cnt); end
    repeat (10) tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    CAM_vsync = 1'b0;
    repeat (3) tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_vs_fall: got %b want 0", overflow); end
  endtask

  task automatic test_reset_midline();
    logic [AW+DW-1:0] got;
    begin_frame();
    for (int r = 0; r < 60; r++) send_line(4, -1, 0);
    for (int i = 0; i < 51; i++) begin
      CAM_href    = 1'b1;
      CAM_px_data = 8'($urandom_range(0, 255));
      tick();
    end
    @(posedge pclk);
    #2 rst = 1'b1;
    #1;
    total++; if (DP_RAM_regW !== 1'b0) begin bad++; $display("FAIL mid_rst_regW: got %b want 0", DP_RAM_regW); end
    total++; if (DP_RAM_addr_in !== '0) begin bad++; $display("FAIL mid_rst_addr: got %0d want 0", DP_RAM_addr_in); end
    tick();
    obs_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      CAM_px_data = 8'($urandom_range(0, 255));
      tick();
    end
    CAM_href = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      CAM_href    = 1'b1;
      CAM_px_data = 8'($urandom_range(0, 255));
      tick();
    end
    CAM_href = 1'b0;
    repeat (4) tick();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_rst_no_writes: got %0d want 0", obs_q.size()); end
    begin_frame();
    send_line(20, -1, 0);
    end_frame();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_restart_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_restart_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    got = (obs_q.size() > 0) ? obs_q[0] : 'x;
    total++; if (got[AW+DW-1:DW] !== 15'd0) begin bad++; $display("FAIL mid_restart_addr0: got %0d want 0", got[AW+DW-1:DW]); end
  endtask

  task automatic test_simultaneous();
    for (int mode = 1; mode <= 2; mode++) begin
      begin_frame();
      send_line(30 + 10 * mode, -1, mode);
      end_frame();
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL simul%0d_count: got %0d want %0d", mode, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL simul%0d_write[%0d]: got %h want %h", mode, i, obs_q[i], exp_q[i]); end
      end
      total++; if (fd_cnt != ((m_row > 0) ? 1 : 0)) begin bad++; $display("FAIL simul%0d_frame_done: got %0d want %0d", mode, fd_cnt, (m_row > 0) ? 1 : 0); end
    end
  endtask

  task automatic test_back_to_back();
    begin_frame();
    for (int r = 0; r < 8; r++) send_line($urandom_range(1, 340), -1, 0);
    end_frame();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad < 20) $display("FAIL b2b_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++; if (merge_cnt != 0) begin bad++; $display("FAIL b2b_merged_strobes: got %0d want 0", merge_cnt); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL b2b_overflow: got %b want %b", overflow, m_ovf); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL b2b_frame_done: got %0d want 1", fd_cnt); end
  endtask

  initial begin
    rst         = 1'b1;
    CAM_vsync   = 1'b0;
    CAM_href    = 1'b0;
    CAM_px_data = 8'h00;
    tick();
    test_reset();
    test_standard_frame();
    test_short_line();
    test_overflow();
    test_reset_midline();
    test_simultaneous();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
